// File: rtl/fft_mag_peak.sv
// Alpha-max-beta-min magnitude of a serial re/im FFT stream with per-frame peak search.
// Optional PEAK_SKIP_DC_EN excludes bin 0 from the peak search.
module fft_mag_peak #(
    parameter int N      = 16,
    parameter int Q      = 8,
    parameter int POINTS = 32,
    parameter int BIN_W  = 5
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_type,
    output logic [N-1:0]     mag_out,
    output logic             mag_valid,
    output logic [BIN_W-1:0] mag_bin,
    output logic [BIN_W-1:0] peak_bin,
    output logic [N-1:0]     peak_mag,
    output logic             peak_valid,
    output logic             proto_err
);

    typedef enum logic {S_RE = 1'b0, S_IM = 1'b1} state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(POINTS - 1);
`ifdef PEAK_SKIP_DC_EN
    localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(1);
`else
    localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(0);
`endif

    // Q only labels the fixed point; magnitude keeps the input scaling.
    if (Q > N) begin : g_q_range
        logic q_too_wide;
        assign q_too_wide = 1'b1;
    end

    state_t             state_q, state_d;
    logic [N-1:0]       re_q, re_d;
    logic               err_q, err_d;
    logic               launch;
    logic               v1_q, v2_q;
    logic [N-1:0]       a_q, b_q;
    logic [N-1:0]       mx, mn, mag_d;
    logic [N-1:0]       mag_q;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   cand_bin_q, cand_bin_d;
    logic [N-1:0]       cand_mag_q, cand_mag_d;
    logic [BIN_W-1:0]   pk_bin_q;
    logic [N-1:0]       pk_mag_q;
    logic               pv_q;

    function automatic logic [N-1:0] abs_f(input logic [N-1:0] x);
        abs_f = x[N-1] ? (~x) + N'(1) : x;
    endfunction

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q <= S_RE;
            re_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        re_d    = re_q;
        err_d   = err_q;
        launch  = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                S_RE: begin
                    if (!in_type) begin
                        re_d    = in_data;
                        state_d = S_IM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_IM: begin
                    if (in_type) begin
                        launch  = 1'b1;
                        state_d = S_RE;
                    end else begin
                        re_d  = in_data;
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // beta = 3/8 via two truncating shifts; sum stays below 2^N.
    always_comb begin
        mx    = (a_q >= b_q) ? a_q : b_q;
        mn    = (a_q >= b_q) ? b_q : a_q;
        mag_d = mx + (mn >> 2) + (mn >> 3);
    end

    always_comb begin
        bin_d      = (bin_q == LAST_BIN) ? '0 : bin_q + BIN_W'(1);
        cand_bin_d = cand_bin_q;
        cand_mag_d = cand_mag_q;
        if (v2_q) begin
            if (bin_q == FIRST_BIN) begin
                cand_bin_d = bin_q;
                cand_mag_d = mag_q;
            end else if (bin_q > FIRST_BIN && mag_q > cand_mag_q) begin
                cand_bin_d = bin_q;
                cand_mag_d = mag_q;
            end
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mag_q      <= '0;
            bin_q      <= '0;
            cand_bin_q <= '0;
            cand_mag_q <= '0;
            pk_bin_q   <= '0;
            pk_mag_q   <= '0;
            pv_q       <= 1'b0;
        end else begin
            v1_q <= launch;
            if (launch) begin
                a_q <= abs_f(re_q);
                b_q <= abs_f(in_data);
            end
            v2_q <= v1_q;
            if (v1_q) mag_q <= mag_d;
            if (v2_q) bin_q <= bin_d;
            cand_bin_q <= cand_bin_d;
            cand_mag_q <= cand_mag_d;
            pv_q <= v2_q && (bin_q == LAST_BIN);
            if (v2_q && bin_q == LAST_BIN) begin
                pk_bin_q <= cand_bin_d;
                pk_mag_q <= cand_mag_d;
            end
        end
    end

    assign mag_out    = mag_q;
    assign mag_valid  = v2_q;
    assign mag_bin    = bin_q;
    assign peak_bin   = pk_bin_q;
    assign peak_mag   = pk_mag_q;
    assign peak_valid = pv_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak with a cycle-timed reference model.
// Honours PEAK_SKIP_DC_EN in both the model and the literal expectations.
module tb_fft_mag_peak;

    localparam int N = 16;
    localparam int PTS = 32;
`ifdef PEAK_SKIP_DC_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic        clk2 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_type = 1'b0;
    logic [15:0] mag_out;
    logic        mag_valid;
    logic [4:0]  mag_bin;
    logic [4:0]  peak_bin;
    logic [15:0] peak_mag;
    logic        peak_valid;
    logic        proto_err;

    fft_mag_peak #(.N(16), .Q(8), .POINTS(32), .BIN_W(5)) dut (
        .clk2(clk2), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_type(in_type), .mag_out(mag_out), .mag_valid(mag_valid),
        .mag_bin(mag_bin), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_valid(peak_valid), .proto_err(proto_err)
    );

    always #5 clk2 = ~clk2;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk2) cyc = cyc + 1;

    // model state
    int mq_cyc[$];
    int mq_mag[$];
    int exp_bin = 0;
    int fm[PTS];
    int pend_cyc = -1;
    int pend_bin = 0, pend_mag = 0;
    int held_bin = 0, held_mag = 0;
    int err_cyc = 32'h7fffffff;
    bit have_re = 0;
    logic [15:0] pre = '0;
    // observations
    int last_mag = 0, last_bin = 0, n_mag = 0;
    int hb[$];
    int hm[$];
    logic [15:0] fr_re[PTS];
    logic [15:0] fr_im[PTS];
    bit exp_pv, exp_mv;
    int m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_mag(input logic [15:0] r, input logic [15:0] i);
        int a, b, mx, mn;
        a = $signed(r);
        b = $signed(i);
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic flag_err();
        if (err_cyc == 32'h7fffffff) err_cyc = cyc + 1;
    endtask

    task automatic send(input logic t, input logic [15:0] d);
        @(posedge clk2);
        #1;
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        if (!t) begin
            if (have_re) flag_err();
            have_re = 1;
            pre = d;
        end else if (!have_re) begin
            flag_err();
        end else begin
            mq_cyc.push_back(cyc + 2);
            mq_mag.push_back(model_mag(pre, d));
            have_re = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk2);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic frame(input int gapmod);
        for (int k = 0; k < PTS; k++) begin
            send(1'b0, fr_re[k]);
            send(1'b1, fr_im[k]);
            if (gapmod > 0) idle(k % gapmod);
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < PTS; k++) begin
            fr_re[k] = '0;
            fr_im[k] = '0;
        end
    endtask

    always @(negedge clk2) begin
        if (!rst) begin
            exp_pv = (cyc == pend_cyc);
            if (exp_pv) begin
                held_bin = pend_bin;
                held_mag = pend_mag;
            end
            chk("peak_valid", peak_valid, exp_pv);
            chk("peak_bin", peak_bin, held_bin);
            chk("peak_mag", peak_mag, held_mag);
            chk("proto_err", proto_err, cyc >= err_cyc);
            exp_mv = mq_cyc.size() > 0 && mq_cyc[0] == cyc;
            chk("mag_valid", mag_valid, exp_mv);
            if (exp_mv) begin
                m = mq_mag.pop_front();
                void'(mq_cyc.pop_front());
                chk("mag_out", mag_out, m);
                chk("mag_bin", mag_bin, exp_bin);
                fm[exp_bin] = m;
                if (exp_bin == PTS - 1) begin
                    pend_bin = FIRST;
                    pend_mag = fm[FIRST];
                    for (int i = FIRST + 1; i < PTS; i++)
                        if (fm[i] > pend_mag) begin
                            pend_bin = i;
                            pend_mag = fm[i];
                        end
                    pend_cyc = cyc + 1;
                end
                exp_bin = (exp_bin + 1) % PTS;
            end
            if (mag_valid) begin
                last_mag = mag_out;
                last_bin = mag_bin;
                n_mag++;
            end
            if (peak_valid) begin
                hb.push_back(peak_bin);
                hm.push_back(peak_mag);
            end
        end
    end

    initial begin
        int nm0;
        repeat (3) @(posedge clk2);
        #3 rst = 1'b0;
        @(negedge clk2);
        #1;
        chk("rst_mag_out", mag_out, 0);
        chk("rst_mag_valid", mag_valid, 0);
        chk("rst_mag_bin", mag_bin, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_proto_err", proto_err, 0);

        // two reals then imag: second real wins
        send(1'b0, 16'h0010);
        send(1'b0, 16'h0020);
        send(1'b1, 16'h0000);
        idle(4);
        chk("perr_mag", last_mag, 16'h0020);
        chk("perr_bin", last_bin, 0);
        chk("perr_flag", proto_err, 1);
        nm0 = n_mag;
        send(1'b1, 16'h1234);
        idle(4);
        chk("perr_drop", n_mag, nm0);

        send(1'b0, 16'h0100);
        send(1'b1, 16'hFF80);
        idle(4);
        chk("arith_304", last_mag, 16'h0130);
        send(1'b0, 16'h8000);
        send(1'b1, 16'h0000);
        idle(4);
        chk("arith_min", last_mag, 16'h8000);

        for (int k = 3; k <= 10; k++) begin
            send(1'b0, 16'(k * 3));
            send(1'b1, 16'(-k));
        end
        send(1'b0, 16'h0055);
        @(posedge clk2);
        #3 rst = 1'b1;
        in_valid = 1'b0;
        mq_cyc.delete();
        mq_mag.delete();
        exp_bin = 0;
        err_cyc = 32'h7fffffff;
        have_re = 0;
        held_bin = 0;
        held_mag = 0;
        pend_cyc = -1;
        #1;
        chk("arst_mag_out", mag_out, 0);
        chk("arst_mag_valid", mag_valid, 0);
        chk("arst_mag_bin", mag_bin, 0);
        chk("arst_peak_bin", peak_bin, 0);
        chk("arst_peak_mag", peak_mag, 0);
        chk("arst_peak_valid", peak_valid, 0);
        chk("arst_proto_err", proto_err, 0);
        @(posedge clk2);
        #3 rst = 1'b0;

        // A: ramp with peak at 17; B..E follow back-to-back
        for (int k = 0; k < PTS; k++) begin
            fr_re[k] = 16'(k * 4);
            fr_im[k] = '0;
        end
        fr_re[17] = 16'h0400;
        frame(0);
        clear_frame();
        fr_re[3] = 16'h0200;
        fr_im[9] = 16'h0200;
        frame(0);
        clear_frame();
        fr_re[31] = 16'hFFFB;
        fr_im[31] = 16'h0003;
        frame(0);
        clear_frame();
        frame(0);
        clear_frame();
        fr_re[0] = 16'h7FFF;
        fr_re[5] = 16'h0100;
        frame(0);
        for (int k = 0; k < PTS; k++) begin
            fr_re[k] = 16'(k * 37 - 600);
            fr_im[k] = 16'(300 - k * 53);
        end
        frame(3);
        idle(8);

        chk("n_peaks", hb.size(), 6);
        chk("A_bin", hb[0], 17);
        chk("A_mag", hm[0], 16'h0400);
        chk("B_tie_bin", hb[1], 3);
        chk("B_tie_mag", hm[1], 16'h0200);
        chk("C_bin", hb[2], 31);
        chk("C_mag", hm[2], 5);
        chk("D_mag", hm[3], 0);
`ifdef PEAK_SKIP_DC_EN
        chk("D_bin", hb[3], 1);
        chk("E_bin", hb[4], 5);
        chk("E_mag", hm[4], 16'h0100);
`else
        chk("D_bin", hb[3], 0);
        chk("E_bin", hb[4], 0);
        chk("E_mag", hm[4], 16'h7FFF);
`endif
        chk("all_consumed", mq_cyc.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Sits directly downstream of the FFT output serializer.
- Consumes its serial stream, where each bin arrives as a real word followed by an imaginary word.
- Computes an alpha-max-beta-min magnitude per bin and emits it as a stream.
- Tracks the largest bin per POINTS-bin frame and reports the frame's peak index and magnitude once the last bin's magnitude has been emitted.

Parameters:
- N, 16: sample word width; input is two's complement.
- Q, 8: fractional bits of the input; passed through only, since magnitude keeps the same Q.
- POINTS, 32: bins per frame.
- BIN_W, 5: bin index width, equal to $clog2(POINTS).

Ports:
- clk2  input  1  system clock; all logic rises on posedge clk2.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  N  serial FFT word.
- in_valid  input  1  in_data valid this cycle.
- in_type  input  1  0 = real part, 1 = imaginary part.
- mag_out  output  N  unsigned magnitude, same Q as input.
- mag_valid  output  1  one-cycle strobe: mag_out and mag_bin are valid.
- mag_bin  output  BIN_W  bin index of mag_out.
- peak_bin  output  BIN_W  index of the frame's largest magnitude.
- peak_mag  output  N  magnitude at peak_bin.
- peak_valid  output  1  one-cycle strobe at end of frame.
- proto_err  output  1  sticky; set on a type-sequence violation.

Behaviour:
- Reset: every output and every internal register goes to 0, and the FSM enters S_RE.
- Reset is asynchronous and active-high, and it also aborts any partial frame in progress.
- FSM states and transitions:
  - S_RE: waits for in_valid with in_type=0. It latches re_q and moves to S_IM.
  - S_RE, in_type=1: the word is dropped, proto_err is set, and the FSM stays in S_RE.
  - S_IM, in_valid with in_type=1: latches the imaginary word, launches the pipeline, and returns to S_RE.
  - S_IM, in_valid with in_type=0: the new word replaces re_q, proto_err is set, and the FSM stays in S_IM.
  - in_valid=0: no state change in either state; gaps of any length are allowed.
- Pipeline stage 1 (register): a=|re|, b=|im|, both unsigned N bits. |-2^(N-1)| = 2^(N-1), which is exact and needs no saturation.
- Pipeline stage 2 (register): mx=max(a,b) and mn=min(a,b). The result is mag = mx + (mn>>2) + (mn>>3), which is beta = 3/8.
  - The maximum result is 1.375*2^(N-1) < 2^N, so no overflow occurs.
  - Truncating shifts are used.
- Latency: mag_valid asserts exactly 2 clk2 cycles after the cycle that accepted the imaginary word.
- A new bin may enter every 2 cycles, with no back-pressure.
- Bin counter:
  - mag_bin = counter value. The counter increments after each mag_valid.
  - It wraps from POINTS-1 to 0.
- Peak tracking, applied on each mag_valid:
  - Bin 0 (first bin of the frame) loads the candidate unconditionally.
  - Later bins replace the candidate only if mag > candidate (strictly greater), so on a tie the lowest index wins.
- End of frame: on the mag_valid for bin POINTS-1:
  - The next cycle drives peak_valid=1 for one cycle, with peak_bin/peak_mag updated to that frame's result, including bin POINTS-1 itself.
  - peak_bin/peak_mag hold until the next frame's peak_valid.
- Simultaneous events: peak_valid for frame k can coincide with mag_valid for bin 0 of frame k+1. Both must be correct: the new frame's candidate is reloaded and the reported peak is unaffected.
- proto_err: cleared only by rst. It does not disturb the bin counter.

Optional Feature:
- Macro: PEAK_SKIP_DC_EN.
- Defined:
  - Bin 0 is excluded from peak search. The candidate loads unconditionally at bin 1.
  - peak_bin is never 0.
  - mag_out for bin 0 is still emitted.
- Undefined: all bins, including bin 0, participate as described above.

Test Plan:
- Reset and idle: assert rst mid-frame after bin 10 -> all outputs 0 immediately (asynchronous). The next frame starts at mag_bin=0 and proto_err=0.
- Magnitude arithmetic:
  - re=0x0100, im=0xFF80 (-128) -> mag_out=0x0130 (304), 2 cycles after the imaginary word.
  - re=0x8000, im=0 -> mag_out=0x8000.
- Full frame, back-to-back (in_valid continuously high, alternating types):
  - Bins 0..31 with re=k*4 and im=0, except bin 17 with re=0x0400 -> peak_valid one cycle after bin 31's mag_valid, with peak_bin=17 and peak_mag=0x0400.
  - The next frame's bin 0 overlaps with no corruption.
- Tie and edge bins:
  - Bins 3 and 9 both give mag 0x0200 (all others 0) -> peak_bin=3.
  - Only bin 31 is non-zero -> peak_bin=31.
  - All zero -> peak_bin=0, peak_mag=0 (without PEAK_SKIP_DC_EN).
- Protocol error: feed two reals 0x0010 then 0x0020, then imag 0 -> proto_err=1 and mag_out=0x0020 for bin 0. Then send an imag while in S_RE -> dropped, with no mag_valid.
- PEAK_SKIP_DC_EN defined: bin 0 = 0x7FFF, bin 5 = 0x0100, others 0 -> peak_bin=5 and peak_mag=0x0100.
